// File: rtl/ts_stream_arbiter_pkg.sv
// Shared constants and FSM encoding for the TS stream arbiter and related QoS schedulers.
package ts_pkg;

    localparam int          TS_PKT_LEN     = 188;
    localparam int          TS_NUM_STREAMS = 4;
    localparam int          TS_DATA_WIDTH  = 8;
    localparam logic [7:0]  TS_SYNC_BYTE   = 8'h47;
    localparam logic [7:0]  TS_LAST_IDX    = 8'(TS_PKT_LEN - 1);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

endpackage

// File: rtl/ts_stream_arbiter_if.sv
// Buffer-side and downstream-side signals of the TS stream arbiter, bundled as one interface.
interface ts_stream_arbiter_if;
    import ts_pkg::*;

    logic [TS_NUM_STREAMS-1:0]               pkt_avail;
    logic [TS_NUM_STREAMS*TS_DATA_WIDTH-1:0] byte_in;
    logic [TS_NUM_STREAMS-1:0]               byte_valid;
    logic [TS_NUM_STREAMS-1:0]               rd_en;
    logic                                    out_ready;
    logic [TS_DATA_WIDTH-1:0]                byte_out;
    logic                                    out_valid;
    logic                                    out_sop;
    logic                                    out_eop;
    logic [TS_NUM_STREAMS-1:0]               grant;
    logic [1:0]                              grant_id;
    logic                                    sync_err;

    modport master (
        input  pkt_avail, byte_in, byte_valid, out_ready,
        output rd_en, byte_out, out_valid, out_sop, out_eop, grant, grant_id, sync_err
    );

    modport slave (
        output pkt_avail, byte_in, byte_valid, out_ready,
        input  rd_en, byte_out, out_valid, out_sop, out_eop, grant, grant_id, sync_err
    );

endinterface

// File: rtl/ts_stream_arbiter_rr_arbiter.sv
// Combinational rotating-priority encoder: picks the first request at or after last+1 (mod 4).
module rr_arbiter (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id
);

    logic       found;
    logic [1:0] idx;

    always_comb begin
        gnt    = '0;
        gnt_id = 2'd0;
        found  = 1'b0;
        idx    = 2'd0;
        // Offset 4 wraps back to 'last' itself, so the previous owner is checked last.
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!found && req[idx]) begin
                found       = 1'b1;
                gnt[idx]    = 1'b1;
                gnt_id      = idx;
            end
        end
    end

endmodule

// File: rtl/ts_stream_arbiter.sv
// Packet-granular round-robin scheduler draining 188-byte TS packets from four FWFT buffers.
// Optional first-byte sync check enabled by defining TS_ARB_SYNC_CHECK_EN.
module ts_stream_arbiter
    import ts_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    ts_stream_arbiter_if.master  bus
);

    arb_state_t state;
    arb_state_t state_next;

    logic [7:0] cnt;
    logic [1:0] last_grant;
    logic [3:0] grant_q;
    logic [1:0] grant_id_q;
    logic [7:0] byte_out_q;
    logic       out_valid_q;
    logic       out_sop_q;
    logic       out_eop_q;

    logic [3:0] rr_gnt;
    logic [1:0] rr_id;
    logic       pop;
    logic       last_byte;
    logic [7:0] head_byte;

    rr_arbiter u_rr (
        .req    (bus.pkt_avail),
        .last   (last_grant),
        .gnt    (rr_gnt),
        .gnt_id (rr_id)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (|bus.pkt_avail)    state_next = XFER;
            XFER: if (pop && last_byte)  state_next = IDLE;
            default:                     state_next = IDLE;
        endcase
    end

    // A pop may refill the output register whenever it is empty or being consumed this cycle.
    always_comb begin
        head_byte = bus.byte_in[{grant_id_q, 3'b000} +: 8];
        last_byte = (cnt == TS_LAST_IDX);
        pop       = (state == XFER) && bus.byte_valid[grant_id_q] && (bus.out_ready || !out_valid_q);
        bus.rd_en = pop ? grant_q : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= 8'd0;
            last_grant  <= 2'd3;
            grant_q     <= 4'b0000;
            grant_id_q  <= 2'd0;
            byte_out_q  <= 8'h00;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
        end else begin
            if (state == IDLE && |bus.pkt_avail) begin
                grant_q    <= rr_gnt;
                grant_id_q <= rr_id;
                last_grant <= rr_id;
                cnt        <= 8'd0;
            end
            if (pop) begin
                byte_out_q  <= head_byte;
                out_valid_q <= 1'b1;
                out_sop_q   <= (cnt == 8'd0);
                out_eop_q   <= last_byte;
                if (last_byte) begin
                    cnt        <= 8'd0;
                    grant_q    <= 4'b0000;
                    grant_id_q <= 2'd0;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
                out_sop_q   <= 1'b0;
                out_eop_q   <= 1'b0;
            end
        end
    end

`ifdef TS_ARB_SYNC_CHECK_EN
    logic sync_err_q;

    always_ff @(posedge clk) begin
        if (rst) sync_err_q <= 1'b0;
        else     sync_err_q <= pop && (cnt == 8'd0) && (head_byte != TS_SYNC_BYTE);
    end

    assign bus.sync_err = sync_err_q;
`else
    assign bus.sync_err = 1'b0;
`endif

    assign bus.byte_out  = byte_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sop   = out_sop_q;
    assign bus.out_eop   = out_eop_q;
    assign bus.grant     = grant_q;
    assign bus.grant_id  = grant_id_q;

endmodule

// File: tb/tb_ts_stream_arbiter.sv
// Directed self-checking bench for ts_stream_arbiter with FWFT buffer models and a byte scoreboard.
module tb_ts_stream_arbiter;

`ifdef TS_ARB_SYNC_CHECK_EN
    localparam int EXP_SYNC = 1;
`else
    localparam int EXP_SYNC = 0;
`endif

    typedef struct packed {
        logic [1:0] s;
        logic [7:0] k;
        logic [7:0] v;
    } exp_t;

    logic clk;
    logic rst;
    logic bad_sync2;

    int   checks;
    int   errors;
    int   cyc;
    int   pos [4];
    exp_t q [$];
    int   ord [$];
    int   lens [$];
    int   sop_cyc [$];
    int   mon_bad;
    int   sync_cnt;
    int   sync_sop;
    int   cur_len;
    int   cur_s;
    int   prev_k;

    ts_stream_arbiter_if bus ();

    ts_stream_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte k of a packet from stream s; byte 0 is the sync byte unless deliberately corrupted.
    function automatic logic [7:0] tbByte(input int s, input int k, input logic bad);
        if (k == 0) return (s == 2 && bad) ? 8'h46 : 8'h47;
        return 8'((s * 37 + k * 3 + 5) % 256);
    endfunction

    always_comb begin
        bus.byte_in = '0;
        for (int s = 0; s < 4; s++) bus.byte_in[s*8 +: 8] = tbByte(s, pos[s], bad_sync2);
    end

    // Upstream buffers: each pop advances the head and queues the byte the output must carry.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int s = 0; s < 4; s++) begin
            if (rst) begin
                pos[s] <= 0;
            end else if (bus.rd_en[s]) begin
                q.push_back({2'(s), 8'(pos[s]), tbByte(s, pos[s], bad_sync2)});
                pos[s] <= (pos[s] == 187) ? 0 : pos[s] + 1;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
        end else begin
            if (bus.sync_err) begin
                sync_cnt++;
                if (bus.out_sop && bus.out_valid) sync_sop++;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    mon_bad++;
                end else begin
                    e = q.pop_front();
                    if (bus.byte_out !== e.v || bus.out_sop !== (e.k == 8'd0) || bus.out_eop !== (e.k == 8'd187))
                        mon_bad++;
                    if (e.k == 8'd0) begin
                        sop_cyc.push_back(cyc);
                        cur_len = 0;
                        cur_s   = int'(e.s);
                    end else if (int'(e.k) != prev_k + 1) begin
                        mon_bad++;
                    end
                    prev_k = int'(e.k);
                    cur_len++;
                    if (e.k == 8'd187) begin
                        ord.push_back(cur_s);
                        lens.push_back(cur_len);
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] pa, input logic [3:0] bv, input logic rdy);
        @(posedge clk);
        #1;
        rst            = r;
        bus.pkt_avail  = pa;
        bus.byte_valid = bv;
        bus.out_ready  = rdy;
    endtask

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitPackets(input int target, input string tag);
        int n;
        n = 0;
        while (ord.size() < target && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({tag, "_timeout"}, 32'(ord.size() >= target), 32'd1);
    endtask

    initial begin
        int   ob;
        int   sb;
        int   sync_base;
        int   sop_base;
        int   n;
        logic [7:0] held;
        int   rr_exp [5] = '{0, 1, 2, 3, 0};
        int   skip_exp [3] = '{1, 3, 1};

        checks = 0; errors = 0; cyc = 0; mon_bad = 0;
        sync_cnt = 0; sync_sop = 0; cur_len = 0; cur_s = 0; prev_k = 0;
        bad_sync2      = 1'b0;
        rst            = 1'b1;
        bus.pkt_avail  = 4'b1111;
        bus.byte_valid = 4'b1111;
        bus.out_ready  = 1'b1;

        // Reset held with every stream requesting
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_rd_en",     32'(bus.rd_en),     32'd0);
        checkOutput("reset_grant",     32'(bus.grant),     32'd0);
        checkOutput("reset_grant_id",  32'(bus.grant_id),  32'd0);
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_byte_out",  32'(bus.byte_out),  32'd0);
        checkOutput("reset_sync_err",  32'(bus.sync_err),  32'd0);

        // Round robin over four always-full streams
        ob = ord.size();
        sb = sop_cyc.size();
        applyStimulus(1'b0, 4'b1111, 4'b1111, 1'b1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("first_grant", 32'(bus.grant), 32'b0001);
        waitPackets(ob + 5, "rr");
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("rr_order%0d", i), 32'(ord[ob+i]), 32'(rr_exp[i]));
            checkOutput($sformatf("rr_len%0d", i), 32'(lens[ob+i]), 32'd188);
        end
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("rr_period%0d", i), 32'(sop_cyc[sb+i+1] - sop_cyc[sb+i]), 32'd189);
        checkOutput("rr_data", 32'(mon_bad), 32'd0);

        // Only streams 1 and 3 available
        applyStimulus(1'b1, 4'b1010, 4'b1111, 1'b1);
        stepCycles(1);
        ob = ord.size();
        applyStimulus(1'b0, 4'b1010, 4'b1111, 1'b1);
        waitPackets(ob + 3, "skip");
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("skip_order%0d", i), 32'(ord[ob+i]), 32'(skip_exp[i]));

        // Backpressure, head-byte stall and pkt_avail drop within one stream-0 packet
        applyStimulus(1'b1, 4'b0000, 4'b1111, 1'b1);
        stepCycles(1);
        ob = ord.size();
        applyStimulus(1'b0, 4'b0001, 4'b1111, 1'b1);
        stepCycles(60);
        bus.out_ready = 1'b0;
        @(negedge clk);
        held = bus.byte_out;
        checkOutput("stall_valid", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("stall_rd_en", 32'(bus.rd_en), 32'd0);
            checkOutput("stall_hold",  32'(bus.byte_out), 32'(held));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        stepCycles(2);
        bus.byte_valid = 4'b1110;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("bv_rd_en", 32'(bus.rd_en), 32'd0);
        end
        checkOutput("bv_drained", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        bus.byte_valid = 4'b1111;
        stepCycles(2);
        bus.pkt_avail = 4'b0000;
        waitPackets(ob + 1, "bp");
        checkOutput("bp_stream", 32'(ord[ob]),  32'd0);
        checkOutput("bp_len",    32'(lens[ob]), 32'd188);
        checkOutput("bp_data",   32'(mon_bad),  32'd0);
        stepCycles(3);
        @(negedge clk);
        checkOutput("bp_idle_grant", 32'(bus.grant),     32'd0);
        checkOutput("bp_idle_valid", 32'(bus.out_valid), 32'd0);

        // Corrupted sync byte on stream 2
        applyStimulus(1'b1, 4'b0000, 4'b1111, 1'b1);
        bad_sync2 = 1'b1;
        sync_base = sync_cnt;
        sop_base  = sync_sop;
        stepCycles(1);
        ob = ord.size();
        applyStimulus(1'b0, 4'b0100, 4'b1111, 1'b1);
        waitPackets(ob + 1, "sync");
        checkOutput("sync_pulses",  32'(sync_cnt - sync_base), 32'(EXP_SYNC));
        checkOutput("sync_on_sop",  32'(sync_sop - sop_base),  32'(EXP_SYNC));
        checkOutput("sync_len",     32'(lens[ob]), 32'd188);
        checkOutput("sync_data",    32'(mon_bad),  32'd0);

        // Reset at byte 100 of stream 1
        applyStimulus(1'b1, 4'b0000, 4'b1111, 1'b1);
        bad_sync2 = 1'b0;
        stepCycles(1);
        applyStimulus(1'b0, 4'b0010, 4'b1111, 1'b1);
        n = 0;
        while (pos[1] != 100 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("mid_reached", 32'(pos[1] == 100), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("mid_rd_en",     32'(bus.rd_en),     32'd0);
        checkOutput("mid_grant",     32'(bus.grant),     32'd0);
        checkOutput("mid_grant_id",  32'(bus.grant_id),  32'd0);
        checkOutput("mid_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("mid_out_sop",   32'(bus.out_sop),   32'd0);
        checkOutput("mid_out_eop",   32'(bus.out_eop),   32'd0);
        checkOutput("mid_byte_out",  32'(bus.byte_out),  32'd0);
        checkOutput("mid_sync_err",  32'(bus.sync_err),  32'd0);
        applyStimulus(1'b0, 4'b1110, 4'b1111, 1'b1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("mid_regrant",    32'(bus.grant),    32'b0010);
        checkOutput("mid_regrant_id", 32'(bus.grant_id), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
